refresh_scheduler: RTL and testbench
====================================

Name: refresh_scheduler

Overview:
DRAM refresh scheduler that sits in front of the DRAM controller's refresh path. It generates the periodic refresh tick: one tick per 64 ms / 4096 rows, which is 390 cycles at 25 MHz. It tracks refresh debt in a saturating pending counter and drives a REQ/ACK/DONE handshake toward the controller, which issues the refresh commands. It is the producer end of the refresh-debt interface; the controller consumes that debt.

Parameters:
INTERVAL, 390, cycles between refresh ticks (≥2)
TIMER_WIDTH, 9, width of interval timer; must hold INTERVAL-1
PEND_WIDTH, 4, width of pending-refresh counter; saturation value MAXP = 2^PEND_WIDTH-1
URGENT_LEVEL, 8, PENDING threshold for REF_URGENT (1..MAXP)

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
ENABLE  input  1  1 = interval timer runs; 0 = timer frozen
REF_ACK  input  1  controller accepts the current refresh request
REF_DONE  input  1  controller has finished the accepted refresh
REF_REQ  output  1  refresh request; Moore output of state REQ
REF_URGENT  output  1  PENDING >= URGENT_LEVEL
PENDING  output  PEND_WIDTH  outstanding refresh count (registered)
OVERFLOW  output  1  sticky: a tick was lost at saturation

Behaviour:
- Reset values: timer=0, PENDING=0, state=IDLE, REF_REQ=0, REF_URGENT=0, OVERFLOW=0.
- RESET overrides everything, including mid-handshake in BUSY. The controller must tolerate an abandoned request.
- Timer:
  - tick = ENABLE & (timer == INTERVAL-1), combinational.
  - On ENABLE, timer increments; on tick it wraps to 0.
  - ENABLE=0 holds the timer value and suppresses ticks.
- Pending counter update at each edge, where dec = (state==REQ) & REF_ACK:
  - tick & !dec: PENDING+1. If PENDING==MAXP, hold MAXP and set OVERFLOW.
  - dec & !tick: PENDING-1. Underflow is impossible because REQ is entered only with PENDING≠0.
  - tick & dec: unchanged.
- OVERFLOW clears only on RESET.
- REF_URGENT is decoded combinationally from the PENDING register. It has no extra latency relative to PENDING.
- FSM states (2-bit):
  - IDLE: REF_REQ=0. If PENDING≠0 → REQ.
  - REQ: REF_REQ=1, held until REF_ACK. On REF_ACK → BUSY and decrement in the same edge.
  - BUSY: REF_REQ=0. On REF_DONE → IDLE.
- Ignored inputs:
  - REF_ACK outside REQ.
  - REF_DONE outside BUSY, including REF_DONE coincident with the accepting REF_ACK.
  - DONE must arrive ≥1 cycle after ACK.
- Latency:
  - Tick at edge k → PENDING updated at edge k.
  - From IDLE, REF_REQ rises at edge k+1.
  - After DONE at edge m, the FSM returns to IDLE. If PENDING≠0, REF_REQ re-asserts at edge m+1, so there is a 1-cycle gap minimum.
- With ENABLE=0, the FSM still drains existing debt.
- Width rule: all arithmetic is unsigned, in PEND_WIDTH / TIMER_WIDTH bits, with no wrap on PENDING.

Decomposition:
- Shared package dram_refresh_pkg:
  - state encodings REF_IDLE=2'd0, REF_REQ_S=2'd1, REF_BUSY=2'd2
  - default constant REF_INTERVAL_25MHZ=390
- One sub-module, refresh_tick_gen:
  - contains the interval timer
  - parameters INTERVAL, TIMER_WIDTH
  - ports CLK, RESET, ENABLE, TICK
- Pending counter and FSM stay in the top module.

Test Plan:
All scenarios use INTERVAL=4, PEND_WIDTH=2 (MAXP=3), URGENT_LEVEL=2.
1. RESET 1 cycle, then ENABLE=1, REF_ACK=0 → tick at 4th edge, PENDING=1; REF_REQ=1 after 5th edge; REF_URGENT=0.
2. In REQ with PENDING=1, pulse REF_ACK 1 cycle → PENDING=0 and REF_REQ=0 next edge (BUSY). REF_DONE 3 cycles later → IDLE; REF_REQ stays 0.
3. PENDING=2 in REQ, REF_ACK coincident with tick → PENDING stays 2, state BUSY, REF_URGENT=1 throughout.
4. No ACKs for 5 intervals → PENDING 1,2,3,3,3; REF_URGENT rises at PENDING=2; OVERFLOW=1 from 4th tick and stays after drain; cleared only by RESET.
5. RESET asserted while BUSY with PENDING=2 → next edge all outputs 0, state IDLE. Subsequent stray REF_DONE and REF_ACK are ignored: no REQ, PENDING=0.
6. PENDING=2, ENABLE=0 for 12 cycles with ACK/DONE serviced → PENDING drains 2→0 and no new ticks. Re-enable → first tick exactly 4−(frozen timer value) cycles later.

Source files
------------

// File: rtl/dram_refresh_pkg.sv
// Shared encodings and defaults for the DRAM refresh path.
package dram_refresh_pkg;

  localparam logic [1:0] REF_IDLE  = 2'd0;
  localparam logic [1:0] REF_REQ_S = 2'd1;
  localparam logic [1:0] REF_BUSY  = 2'd2;

  // 64 ms / 4096 rows at 25 MHz
  localparam int REF_INTERVAL_25MHZ = 390;

endpackage

// File: rtl/refresh_tick_gen.sv
// Interval timer: emits a one-cycle TICK every INTERVAL enabled cycles.
// Combinational TICK; timer freezes while ENABLE is low.
module refresh_tick_gen
  import dram_refresh_pkg::*;
#(
  parameter int INTERVAL    = REF_INTERVAL_25MHZ,
  parameter int TIMER_WIDTH = 9
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TICK
);

  logic [TIMER_WIDTH-1:0] timer_q;
  logic [TIMER_WIDTH-1:0] timer_d;

  assign TICK = ENABLE & (timer_q == TIMER_WIDTH'(INTERVAL - 1));

  always_comb begin
    timer_d = timer_q;
    if (TICK) begin
      timer_d = '0;
    end else if (ENABLE) begin
      timer_d = timer_q + TIMER_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh scheduler: tracks refresh debt and hands it to the controller via REQ/ACK/DONE.
// REQ rises one edge after debt appears; ACK decrements debt on the accepting edge.
module refresh_scheduler
  import dram_refresh_pkg::*;
#(
  parameter int INTERVAL     = REF_INTERVAL_25MHZ,
  parameter int TIMER_WIDTH  = 9,
  parameter int PEND_WIDTH   = 4,
  parameter int URGENT_LEVEL = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  REF_ACK,
  input  logic                  REF_DONE,
  output logic                  REF_REQ,
  output logic                  REF_URGENT,
  output logic [PEND_WIDTH-1:0] PENDING,
  output logic                  OVERFLOW
);

  localparam logic [PEND_WIDTH-1:0] MAXP = '1;

  logic                  tick;
  logic                  dec;
  logic [1:0]            state_q, state_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;

  refresh_tick_gen #(
    .INTERVAL    (INTERVAL),
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_tick_gen (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .TICK   (tick)
  );

  assign dec = (state_q == REF_REQ_S) & REF_ACK;

  // A tick that lands at saturation is lost and flagged; REQ is only entered
  // with nonzero debt, so the decrement can never underflow.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (tick && !dec) begin
      if (pend_q == MAXP) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_WIDTH'(1);
      end
    end else if (dec && !tick) begin
      pend_d = pend_q - PEND_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REF_IDLE:  if (pend_q != '0) state_d = REF_REQ_S;
      REF_REQ_S: if (REF_ACK)      state_d = REF_BUSY;
      REF_BUSY:  if (REF_DONE)     state_d = REF_IDLE;
      default:                     state_d = REF_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= REF_IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign REF_REQ    = (state_q == REF_REQ_S);
  assign REF_URGENT = (pend_q >= PEND_WIDTH'(URGENT_LEVEL));
  assign PENDING    = pend_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler with INTERVAL=4, MAXP=3, URGENT_LEVEL=2.
module tb_refresh_scheduler;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic       REF_ACK = 1'b0;
  logic       REF_DONE = 1'b0;
  logic       REF_REQ;
  logic       REF_URGENT;
  logic [1:0] PENDING;
  logic       OVERFLOW;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  refresh_scheduler #(
    .INTERVAL     (4),
    .TIMER_WIDTH  (2),
    .PEND_WIDTH   (2),
    .URGENT_LEVEL (2)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .REF_ACK    (REF_ACK),
    .REF_DONE   (REF_DONE),
    .REF_REQ    (REF_REQ),
    .REF_URGENT (REF_URGENT),
    .PENDING    (PENDING),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Expected output bundle {REQ, URGENT, PENDING[1:0], OVERFLOW}
  function automatic logic [4:0] E(input logic req, input logic urg,
                                   input int pend, input logic ovf);
    logic [1:0] p;
    p = pend[1:0];
    return {req, urg, p, ovf};
  endfunction

  // Drive one cycle of inputs, queue the outputs expected after the edge,
  // then pop and compare on the following falling edge.
  task automatic cyc(input string tag, input logic rst, input logic en,
                     input logic ack, input logic done, input logic [4:0] exp);
    logic [4:0] got;
    logic [4:0] want;
    string      t;
    RESET    = rst;
    ENABLE   = en;
    REF_ACK  = ack;
    REF_DONE = done;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge CLK);
    @(negedge CLK);
    got  = {REF_REQ, REF_URGENT, PENDING, OVERFLOW};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed req/urg/pend/ovf=%b expected %b", t, got, want);
    end
  endtask

  initial begin
    cyc("reset", 1, 0, 0, 0, E(0, 0, 0, 0));

    // 1: first tick on the 4th edge, REQ one edge later
    for (int i = 0; i < 3; i++) cyc("t1_count", 0, 1, 0, 0, E(0, 0, 0, 0));
    cyc("t1_tick", 0, 1, 0, 0, E(0, 0, 1, 0));
    cyc("t1_req",  0, 1, 0, 0, E(1, 0, 1, 0));

    // 2: ACK drains to 0, DONE returns to IDLE, stray ACK in IDLE ignored (timer frozen at 1)
    cyc("t2_ack", 0, 0, 1, 0, E(0, 0, 0, 0));
    for (int i = 0; i < 2; i++) cyc("t2_busy", 0, 0, 0, 0, E(0, 0, 0, 0));
    cyc("t2_done",      0, 0, 0, 1, E(0, 0, 0, 0));
    cyc("t2_stray_ack", 0, 0, 1, 0, E(0, 0, 0, 0));
    cyc("t2_idle",      0, 0, 0, 0, E(0, 0, 0, 0));

    // 3: timer resumes from 1; ACK coincident with tick keeps PENDING at 2
    for (int i = 0; i < 2; i++) cyc("t3_count", 0, 1, 0, 0, E(0, 0, 0, 0));
    cyc("t3_tick1", 0, 1, 0, 0, E(0, 0, 1, 0));
    for (int i = 0; i < 3; i++) cyc("t3_req1", 0, 1, 0, 0, E(1, 0, 1, 0));
    cyc("t3_tick2", 0, 1, 0, 0, E(1, 1, 2, 0));
    for (int i = 0; i < 3; i++) cyc("t3_req2", 0, 1, 0, 0, E(1, 1, 2, 0));
    cyc("t3_coinc", 0, 1, 1, 0, E(0, 1, 2, 0));
    cyc("t3_busy",  0, 1, 0, 0, E(0, 1, 2, 0));
    cyc("t3_done",  0, 1, 0, 1, E(0, 1, 2, 0));
    cyc("t3_rereq", 0, 1, 0, 0, E(1, 1, 2, 0));

    // 4: saturation and sticky overflow
    cyc("t4_reset", 1, 1, 0, 0, E(0, 0, 0, 0));
    for (int i = 1; i <= 20; i++) begin
      int p;
      p = (i / 4 > 3) ? 3 : i / 4;
      cyc($sformatf("t4_edge%0d", i), 0, 1, 0, 0,
          E(i >= 5, p >= 2, p, i >= 16));
    end
    cyc("t4_ack1",  0, 0, 1, 0, E(0, 1, 2, 1));
    cyc("t4_done1", 0, 0, 0, 1, E(0, 1, 2, 1));
    cyc("t4_req2",  0, 0, 0, 0, E(1, 1, 2, 1));
    cyc("t4_ack2",  0, 0, 1, 0, E(0, 0, 1, 1));
    cyc("t4_done2", 0, 0, 0, 1, E(0, 0, 1, 1));
    cyc("t4_req3",  0, 0, 0, 0, E(1, 0, 1, 1));
    cyc("t4_ack3",  0, 0, 1, 0, E(0, 0, 0, 1));
    cyc("t4_done3", 0, 0, 0, 1, E(0, 0, 0, 1));
    cyc("t4_ovf_sticky", 0, 0, 0, 0, E(0, 0, 0, 1));

    // 5: reset clears overflow and aborts a BUSY handshake
    cyc("t5_reset_clr", 1, 0, 0, 0, E(0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc("t5_count", 0, 1, 0, 0, E(0, 0, 0, 0));
    cyc("t5_tick1", 0, 1, 0, 0, E(0, 0, 1, 0));
    for (int i = 0; i < 3; i++) cyc("t5_req1", 0, 1, 0, 0, E(1, 0, 1, 0));
    for (int i = 0; i < 4; i++) cyc("t5_req2", 0, 1, 0, 0, E(1, 1, 2, 0));
    cyc("t5_coinc",      0, 1, 1, 0, E(0, 1, 2, 0));
    cyc("t5_reset_busy", 1, 0, 0, 0, E(0, 0, 0, 0));
    cyc("t5_stray_done", 0, 0, 0, 1, E(0, 0, 0, 0));
    cyc("t5_stray_ack",  0, 0, 1, 0, E(0, 0, 0, 0));
    cyc("t5_idle",       0, 0, 0, 0, E(0, 0, 0, 0));

    // 6: drain with timer frozen at 2, then first tick 2 cycles after re-enable
    for (int i = 0; i < 3; i++) cyc("t6_count", 0, 1, 0, 0, E(0, 0, 0, 0));
    cyc("t6_tick1", 0, 1, 0, 0, E(0, 0, 1, 0));
    for (int i = 0; i < 3; i++) cyc("t6_req1", 0, 1, 0, 0, E(1, 0, 1, 0));
    for (int i = 0; i < 3; i++) cyc("t6_req2", 0, 1, 0, 0, E(1, 1, 2, 0));
    cyc("t6_ack1",  0, 0, 1, 0, E(0, 0, 1, 0));
    cyc("t6_done1", 0, 0, 0, 1, E(0, 0, 1, 0));
    cyc("t6_req3",  0, 0, 0, 0, E(1, 0, 1, 0));
    cyc("t6_ack2",  0, 0, 1, 0, E(0, 0, 0, 0));
    cyc("t6_done2", 0, 0, 0, 1, E(0, 0, 0, 0));
    for (int i = 0; i < 7; i++) cyc("t6_frozen", 0, 0, 0, 0, E(0, 0, 0, 0));
    cyc("t6_reen",       0, 1, 0, 0, E(0, 0, 0, 0));
    cyc("t6_first_tick", 0, 1, 0, 0, E(0, 0, 1, 0));
    cyc("t6_req",        0, 1, 0, 0, E(1, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
